// File: rtl/bsg_downstream_in_assembler.sv
`default_nettype none
// ============================================================================
// Module   : bsg_downstream_in_assembler
// Purpose  : Receiving end of a two-channel source-synchronous link. Beats
//            from both channels are paired into words of 4*ch_width_p bits.
//            The words are buffered for the core behind a valid/yumi
//            handshake. Credit goes back to the transmitter as a toggling
//            token, with one toggle per token_every_p words consumed.
// Ports    : clk            - sole clock, rising edge
//            rst            - asynchronous active-high reset
//            io_valid_i     - beat present on both channels
//            io_data_ch0_i  - channel 0 beat data
//            io_data_ch1_i  - channel 1 beat data
//            valid_o        - buffer non-empty
//            data_o         - oldest buffered word
//            core_yumi_i    - core consumes data_o this cycle
//            token_o        - credit token (toggles)
//            overflow_o     - sticky: a completed word was dropped
// Revision : 1.0 - initial release
// ============================================================================
module bsg_downstream_in_assembler #(
  parameter int ch_width_p    = 16,
  parameter int fifo_els_p    = 4,
  parameter int token_every_p = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_valid_i,
  input  logic [ch_width_p-1:0]   io_data_ch0_i,
  input  logic [ch_width_p-1:0]   io_data_ch1_i,
  output logic                    valid_o,
  output logic [4*ch_width_p-1:0] data_o,
  input  logic                    core_yumi_i,
  output logic                    token_o,
  output logic                    overflow_o
);

  localparam int c_WORD_W = 4 * ch_width_p;
  localparam int c_HOLD_W = 2 * ch_width_p;
  localparam int c_PTR_W  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_TOK_W  = (token_every_p > 1) ? $clog2(token_every_p) : 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(fifo_els_p);
  localparam logic [c_TOK_W-1:0] c_TOK_LAST = c_TOK_W'(token_every_p - 1);

  // Beat assembly state
  logic                r_phase;
  logic [c_HOLD_W-1:0] r_hold;

  // Word buffer state
  logic [c_WORD_W-1:0] r_mem [fifo_els_p];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  // Credit / status state
  logic [c_TOK_W-1:0]  r_tok_cnt;
  logic                r_token;
  logic                r_overflow;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_accept;
  logic                w_drop;
  logic [c_WORD_W-1:0] w_word;

  assign w_push = io_valid_i & r_phase;
  assign w_pop  = core_yumi_i & (r_count != '0);
  assign w_full = (r_count == c_DEPTH);
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_word   = {io_data_ch1_i, io_data_ch0_i, r_hold};

  // Beat phase and first-beat holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_hold  <= '0;
    end else if (io_valid_i) begin
      if (!r_phase) begin
        r_hold  <= {io_data_ch1_i, io_data_ch0_i};
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

  // Circular word buffer. Depth is a power of two, so the pointers wrap
  // naturally on overflow of their own width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < fifo_els_p; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Credit token: toggles on every token_every_p-th pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tok_cnt <= '0;
      r_token   <= 1'b0;
    end else if (w_pop) begin
      if (r_tok_cnt == c_TOK_LAST) begin
        r_tok_cnt <= '0;
        r_token   <= ~r_token;
      end else begin
        r_tok_cnt <= r_tok_cnt + c_TOK_W'(1);
      end
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign valid_o    = (r_count != '0);
  assign data_o     = r_mem[r_rd_ptr];
  assign token_o    = r_token;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_in_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_downstream_in_assembler
// Purpose  : Self-checking bench for bsg_downstream_in_assembler (default
//            parameters: 16-bit channels, depth 4, token every 2 pops).
//            It has a constant vector table, hand sequences for the
//            multi-cycle corners, and randomized traffic checked against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_downstream_in_assembler;

  localparam int c_DEPTH = 4;
  localparam int c_TE    = 2;

  logic        clk;
  logic        rst;
  logic        io_valid_i;
  logic [15:0] io_data_ch0_i;
  logic [15:0] io_data_ch1_i;
  logic        valid_o;
  logic [63:0] data_o;
  logic        core_yumi_i;
  logic        token_o;
  logic        overflow_o;

  bsg_downstream_in_assembler #(
    .ch_width_p   (16),
    .fifo_els_p   (c_DEPTH),
    .token_every_p(c_TE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_i   (io_valid_i),
    .io_data_ch0_i(io_data_ch0_i),
    .io_data_ch1_i(io_data_ch1_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .core_yumi_i  (core_yumi_i),
    .token_o      (token_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word queue, beat phase, pop total, sticky drop flag
  logic [63:0] mq[$];
  logic        m_phase;
  logic [31:0] m_hold;
  int          m_pops;
  logic        m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 1'b0;
    m_hold  = '0;
    m_pops  = 0;
    m_ovf   = 1'b0;
  endtask

  // Called #1 after a rising edge. Pulses reset asynchronously, checks the
  // outputs while reset is held, then releases away from the clock edge.
  task automatic do_reset();
    io_valid_i    = 1'b0;
    core_yumi_i   = 1'b0;
    io_data_ch0_i = '0;
    io_data_ch1_i = '0;
    rst = 1'b1;
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_token", 64'(token_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle of stimulus, with model update and comparison after the edge
  task automatic step(input logic v, input logic [15:0] c0, input logic [15:0] c1,
                      input logic y);
    logic pop;
    logic push;
    logic full_before;
    io_valid_i    = v;
    io_data_ch0_i = c0;
    io_data_ch1_i = c1;
    core_yumi_i   = y;
    full_before = (mq.size() == c_DEPTH);
    pop  = y && (mq.size() > 0);
    push = v && m_phase;
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (push) begin
      if (!full_before || pop) mq.push_back({c1, c0, m_hold});
      else                     m_ovf = 1'b1;
    end
    if (v) begin
      if (!m_phase) begin
        m_hold  = {c1, c0};
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("m_valid", 64'(valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", data_o, mq[0]);
    chk("m_token", 64'(token_o), 64'((m_pops / c_TE) % 2));
    chk("m_overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  function automatic logic [63:0] wordk(input int k);
    logic [15:0] a, b, c, d;
    a = 16'(4 * k);
    b = 16'(4 * k + 1);
    c = 16'(4 * k + 2);
    d = 16'(4 * k + 3);
    return {d, c, b, a};
  endfunction

  task automatic push_word(input int k, input logic y1, input logic y2);
    step(1'b1, 16'(4 * k),     16'(4 * k + 1), y1);
    step(1'b1, 16'(4 * k + 2), 16'(4 * k + 3), y2);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] c0;
    logic [15:0] c1;
    logic        y;
    logic        ev;
    logic [63:0] ed;
    logic        et;
    logic        eo;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [1:0] exp_tok [4];
    rst = 1'b0;
    model_reset();
    do_reset();

    // ---------------- table-driven vectors from reset ----------------
    tbl[0]  = '{1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h3333, 16'h4444, 1'b0, 1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'hCCCC, 16'hDDDD, 1'b0, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].c0, tbl[i].c1, tbl[i].y);
      chk($sformatf("tbl%0d_valid", i), 64'(valid_o), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
      chk($sformatf("tbl%0d_token", i), 64'(token_o), 64'(tbl[i].et));
      chk($sformatf("tbl%0d_overflow", i), 64'(overflow_o), 64'(tbl[i].eo));
    end

    // ---------------- token cadence, yumi held high ----------------
    do_reset();
    exp_tok[0] = 2'd0; exp_tok[1] = 2'd1; exp_tok[2] = 2'd1; exp_tok[3] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'(4 * k), 16'(4 * k + 1), 1'b1);
      if (k > 0) chk($sformatf("cad_tok_pop%0d", k), 64'(token_o), 64'(exp_tok[k-1]));
      step(1'b1, 16'(4 * k + 2), 16'(4 * k + 3), 1'b1);
      chk($sformatf("cad_word%0d", k), data_o, wordk(k));
    end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("cad_tok_pop5", 64'(token_o), 64'd0);
    chk("cad_valid_empty", 64'(valid_o), 64'd0);
    push_word(9, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("cad_tok_pop6", 64'(token_o), 64'd1);

    // ---------------- full / overflow ----------------
    do_reset();
    for (int k = 1; k <= 4; k++) push_word(k, 1'b0, 1'b0);
    chk("full_no_ovf_yet", 64'(overflow_o), 64'd0);
    push_word(5, 1'b0, 1'b0);
    chk("full_drop_ovf", 64'(overflow_o), 64'd1);
    chk("full_head", data_o, wordk(1));
    // Clear the sticky flag so the simultaneous push/pop case is observable.
    do_reset();
    for (int k = 1; k <= 4; k++) push_word(k, 1'b0, 1'b0);
    push_word(6, 1'b0, 1'b1);
    chk("full_pp_no_ovf", 64'(overflow_o), 64'd0);
    chk("full_pp_head", data_o, wordk(2));
    push_word(7, 1'b0, 1'b0);
    chk("full_drop2_ovf", 64'(overflow_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_order%0d", k), data_o, (k == 3) ? wordk(6) : wordk(k + 2));
      step(1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("full_drained", 64'(valid_o), 64'd0);
    chk("full_ovf_sticky", 64'(overflow_o), 64'd1);

    // ---------------- reset mid-word ----------------
    step(1'b1, 16'hAAAA, 16'hBBBB, 1'b0);
    do_reset();
    step(1'b1, 16'h0001, 16'h0002, 1'b0);
    chk("midrst_no_valid", 64'(valid_o), 64'd0);
    step(1'b1, 16'h0003, 16'h0004, 1'b0);
    chk("midrst_word", data_o, 64'h0004_0003_0002_0001);
    chk("midrst_valid", 64'(valid_o), 64'd1);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      int ypct;
      ypct = (seg == 0) ? 90 : (seg == 1) ? 50 : 10;
      for (int c = 0; c < 600; c++) begin
        step(($urandom_range(99) < 70), 16'($urandom), 16'($urandom),
             (int'($urandom_range(99)) < ypct));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
